// File: rtl/scp_079.sv
// Purpose : SCP-079 containment monitor FSM; 1 clock = 1 simulated second.
// Latency : inputs sampled at edge k set state/timer at edge k; outputs are Moore-decoded from state.
// Backpr. : none, status inputs are level-sampled every cycle and never stalled.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   green, yellow, red       containment status (red > yellow > green, none = yellow)
//   state[2:0], timer[5:0]   current state code and cycles spent in it (saturates at 63)
//   a1, a2, a3, cheat_out    alarm levels and breach flag, decoded from state only
module scp_079 (
   input  logic       clock,
   input  logic       reset,
   input  logic       green,
   input  logic       yellow,
   input  logic       red,
   output logic [2:0] state,
   output logic [5:0] timer,
   output logic       a1,
   output logic       a2,
   output logic       a3,
   output logic       cheat_out
);

   typedef enum logic [2:0] {
      ST_OK      = 3'd0,
      ST_PROBE   = 3'd1,
      ST_ATTACK  = 3'd2,
      ST_WARN    = 3'd3,
      ST_ALARM   = 3'd4,
      ST_BREACH  = 3'd5,
      ST_FAILED  = 3'd6,
      ST_ILLEGAL = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      LV_GRN = 2'd0,
      LV_YEL = 2'd1,
      LV_RED = 2'd2
   } level_t;

   state_t     cur_state;
   state_t     nxt_state;
   level_t     level;
   logic [3:0] grun;
   logic       is_grn;
   logic       change;

   // Effective level: red dominates, and "no input" counts as caution.
   always_comb begin
      if (red)
         level = LV_RED;
      else if (yellow)
         level = LV_YEL;
      else if (green)
         level = LV_GRN;
      else
         level = LV_YEL;
   end

   assign is_grn = (level == LV_GRN);

   // Next-state logic. Within each state the checks are ordered by priority;
   // timer/grun compare against N-1 because they hold the count of cycles
   // already completed before this edge.
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         ST_OK: begin
            if (level == LV_RED)
               nxt_state = ST_ALARM;
            else if (level == LV_YEL)
               nxt_state = ST_WARN;
            else if (timer == 6'd19)
               nxt_state = ST_PROBE;
         end
         ST_PROBE: begin
            if (level == LV_RED)
               nxt_state = ST_ALARM;
            else if (level == LV_YEL)
               nxt_state = ST_WARN;
            else if (timer == 6'd9)
               nxt_state = ST_ATTACK;
         end
         ST_ATTACK: begin
            if (level == LV_RED)
               nxt_state = ST_BREACH;
            else if (level == LV_YEL)
               nxt_state = ST_WARN;
            else if (timer == 6'd14)
               nxt_state = ST_OK;
         end
         ST_WARN: begin
            if (level == LV_RED)
               nxt_state = ST_ALARM;
            else if (is_grn && grun == 4'd4)
               nxt_state = ST_OK;
            else if (timer == 6'd29)
               nxt_state = ST_ALARM;
         end
         ST_ALARM: begin
            if (is_grn && grun == 4'd9)
               nxt_state = ST_OK;
            else if (timer == 6'd62)
               nxt_state = ST_FAILED;
         end
         ST_BREACH: begin
            if (is_grn && grun == 4'd9)
               nxt_state = ST_OK;
            else if (timer == 6'd19)
               nxt_state = ST_FAILED;
         end
         ST_FAILED: begin
            nxt_state = ST_FAILED;
         end
         default: begin
            nxt_state = ST_OK;
         end
      endcase
   end

   // The illegal code always changes state, so its exit also clears timer.
   assign change = (nxt_state != cur_state);

   // State register plus the two per-state counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         cur_state <= ST_OK;
         timer     <= 6'd0;
         grun      <= 4'd0;
      end else begin
         cur_state <= nxt_state;
         if (change) begin
            timer <= 6'd0;
            grun  <= 4'd0;
         end else begin
            if (timer != 6'd63)
               timer <= timer + 6'd1;
            if (!is_grn)
               grun <= 4'd0;
            else if (grun != 4'd15)
               grun <= grun + 4'd1;
         end
      end
   end

   assign state = cur_state;

   // Moore output decode.
   always_comb begin
      a1        = 1'b0;
      a2        = 1'b0;
      a3        = 1'b0;
      cheat_out = 1'b0;
      case (cur_state)
         ST_PROBE: begin
            a1 = 1'b1;
         end
         ST_ATTACK: begin
            a1 = 1'b1;
            a2 = 1'b1;
         end
         ST_WARN: begin
            a2 = 1'b1;
         end
         ST_ALARM: begin
            a3 = 1'b1;
         end
         ST_BREACH, ST_FAILED: begin
            a1        = 1'b1;
            a2        = 1'b1;
            a3        = 1'b1;
            cheat_out = 1'b1;
         end
         default: begin
            a1 = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_scp_079.sv
module tb_scp_079;

   logic       clock;
   logic       reset;
   logic       green;
   logic       yellow;
   logic       red;
   logic [2:0] state;
   logic [5:0] timer;
   logic       a1;
   logic       a2;
   logic       a3;
   logic       cheat_out;

   int checks   = 0;
   int failures = 0;

   scp_079 dut (
      .clock     (clock),
      .reset     (reset),
      .green     (green),
      .yellow    (yellow),
      .red       (red),
      .state     (state),
      .timer     (timer),
      .a1        (a1),
      .a2        (a2),
      .a3        (a3),
      .cheat_out (cheat_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- reference model (table driven) ----------------
   // Per state: dwell length, where the dwell expires to, red/yellow targets
   // (-1 = ignored), consecutive greens needed to recover (0 = none),
   // and the {a1,a2,a3,cheat} pattern.
   int lim    [0:5] = '{20, 10, 15, 30, 63, 20};
   int tmo    [0:5] = '{1, 2, 0, 4, 6, 6};
   int on_red [0:5] = '{4, 4, 5, 4, -1, -1};
   int on_yel [0:5] = '{3, 3, 3, -1, -1, -1};
   int gneed  [0:5] = '{0, 0, 0, 5, 10, 10};
   int out_tab[0:6] = '{0, 8, 12, 4, 2, 15, 15};

   int m_state = 0;
   int m_timer = 0;
   int m_grun  = 0;
   int m_lvl;
   int m_ns;
   bit model_ok = 1'b0;

   always @(posedge clock) begin
      if (reset) begin
         m_state  = 0;
         m_timer  = 0;
         m_grun   = 0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         m_lvl = red ? 2 : (yellow ? 1 : (green ? 0 : 1));
         m_ns  = m_state;
         if (m_state != 6) begin
            if (m_lvl == 2 && on_red[m_state] >= 0)
               m_ns = on_red[m_state];
            else if (m_lvl == 1 && on_yel[m_state] >= 0)
               m_ns = on_yel[m_state];
            else if (m_lvl == 0 && gneed[m_state] > 0 && m_grun + 1 == gneed[m_state])
               m_ns = 0;
            else if (m_timer + 1 == lim[m_state])
               m_ns = tmo[m_state];
         end
         if (m_ns != m_state) begin
            m_state = m_ns;
            m_timer = 0;
            m_grun  = 0;
         end else begin
            m_timer = (m_timer >= 63) ? 63 : m_timer + 1;
            m_grun  = (m_lvl != 0) ? 0 : ((m_grun >= 15) ? 15 : m_grun + 1);
         end
      end
   end

   // Per-cycle compare of all outputs against the model.
   always @(negedge clock) begin
      if (model_ok) begin
         checks++;
         if ({state, timer, a1, a2, a3, cheat_out} !== {3'(m_state), 6'(m_timer), 4'(out_tab[m_state])}) begin
            failures++;
            $display("FAIL model_cmp t=%0t: got state=%0d timer=%0d out=%b%b%b%b expected state=%0d timer=%0d out=%b",
                     $time, state, timer, a1, a2, a3, cheat_out, m_state, m_timer, 4'(out_tab[m_state]));
         end
      end
   end

   // ---------------- literal checks ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int outs();
      return int'({a1, a2, a3, cheat_out});
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Input pattern for scenario kind at cycle c, as {green,yellow,red}.
   function automatic logic [2:0] pattern(input int kind, input int c);
      case (kind)
         0: return 3'b100;
         1: return (c >= 40) ? 3'b001 : 3'b100;
         2: return (c >= 40 && c < 45) ? 3'b001 : 3'b100;
         3: return (c == 5) ? 3'b010 : 3'b100;
         default: return 3'b010;
      endcase
   endfunction

   // Hand-derived expectations from the scenario walkthroughs.
   task automatic pin(input int kind, input int c);
      case (kind)
         0: begin
            if (c == 19) chk("grn_c19_state", state, 0);
            if (c == 20) chk("grn_c20_state", state, 1);
            if (c == 20) chk("grn_c20_out", outs(), 8);
            if (c == 30) chk("grn_c30_out", outs(), 12);
            if (c == 45) chk("grn_c45_state", state, 0);
            if (c == 45) chk("grn_c45_timer", timer, 0);
            if (c == 65) chk("grn_c65_state", state, 1);
         end
         1: begin
            if (c == 40) chk("red_c40_state", state, 2);
            if (c == 41) chk("red_c41_state", state, 5);
            if (c == 41) chk("red_c41_out", outs(), 15);
            if (c == 60) chk("red_c60_state", state, 5);
            if (c == 61) chk("red_c61_state", state, 6);
            if (c == 90) chk("red_c90_cheat", cheat_out, 1);
         end
         2: begin
            if (c == 54) chk("rec_c54_state", state, 5);
            if (c == 55) chk("rec_c55_state", state, 0);
            if (c == 56) chk("rec_c56_cheat", cheat_out, 0);
         end
         3: begin
            if (c == 6)  chk("yel1_c6_state", state, 3);
            if (c == 10) chk("yel1_c10_state", state, 3);
            if (c == 11) chk("yel1_c11_state", state, 0);
         end
         default: begin
            if (c == 1)   chk("yel_c1_state", state, 3);
            if (c == 31)  chk("yel_c31_state", state, 4);
            if (c == 31)  chk("yel_c31_a3", a3, 1);
            if (c == 93)  chk("yel_c93_state", state, 4);
            if (c == 94)  chk("yel_c94_state", state, 6);
            if (c == 156) chk("yel_c156_timer", timer, 62);
            if (c == 170) chk("yel_c170_timer_sat", timer, 63);
         end
      endcase
   endtask

   task automatic run_scn(input int kind, input int n);
      logic [2:0] gyr;
      for (int c = 0; c < n; c++) begin
         gyr    = pattern(kind, c);
         green  = gyr[2];
         yellow = gyr[1];
         red    = gyr[0];
         @(negedge clock);
         pin(kind, c);
         @(posedge clock);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int         seg;
      int         w;
      logic [2:0] cur;
      seg    = 0;
      cur    = 3'b100;
      reset  = 1'b1;
      green  = 1'b0;
      yellow = 1'b0;
      red    = 1'b0;
      @(posedge clock);
      #1;
      do_reset();
      @(negedge clock);
      chk("reset_state", state, 0);
      chk("reset_timer", timer, 0);
      chk("reset_outs", outs(), 0);
      @(posedge clock);
      #1;

      do_reset();
      run_scn(0, 100);
      do_reset();
      run_scn(1, 95);
      // Reset out of FAILED.
      chk("pre_reset_failed", state, 6);
      do_reset();
      @(negedge clock);
      chk("post_fail_reset_state", state, 0);
      chk("post_fail_reset_timer", timer, 0);
      chk("post_fail_reset_outs", outs(), 0);
      @(posedge clock);
      #1;
      do_reset();
      run_scn(2, 80);
      do_reset();
      run_scn(3, 30);
      do_reset();
      run_scn(4, 175);

      // Randomized segments with rare mid-run resets.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (seg == 0) begin
            seg = $urandom_range(1, 25);
            w   = $urandom_range(0, 99);
            if (w < 55)      cur = 3'b100;
            else if (w < 75) cur = 3'b010;
            else if (w < 85) cur = 3'b001;
            else if (w < 92) cur = 3'b000;
            else             cur = 3'($urandom);
         end
         seg--;
         green  = cur[2];
         yellow = cur[1];
         red    = cur[0];
         reset  = ($urandom_range(0, 599) == 0);
         @(posedge clock);
         #1;
      end
      reset = 1'b0;
      @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
